// File: rtl/render_tile_scheduler_pkg.sv
// Shared types and helpers for the render tile scheduler.
package render_tile_scheduler_pkg;

  // Default frame geometry (QVGA frame split into 16x16 tiles).
  localparam int DEF_TOTAL_ROWS = 240;
  localparam int DEF_TOTAL_COLS = 320;
  localparam int DEF_TILE_ROWS  = 16;
  localparam int DEF_TILE_COLS  = 16;

  // Width of the tile origin fields carried in a descriptor.
  localparam int DESC_POS_BITS = 9;

  // Number of tiles along one frame axis.
  function automatic int tiles_along(input int total, input int tile);
    return total / tile;
  endfunction

  // Pixels (and pixel-buffer bytes) covered by one tile.
  function automatic int tile_pixels(input int tile_rows, input int tile_cols);
    return tile_rows * tile_cols;
  endfunction

  // Everything a render unit needs to locate its tile.
  typedef struct packed {
    logic [DESC_POS_BITS-1:0] start_row;
    logic [DESC_POS_BITS-1:0] start_col;
    logic [31:0]              pixel_buffer;
  } tile_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/render_tile_scheduler_tile_unit_tracker.sv
// Per-unit bookkeeping: busy flag, tile descriptor, do_render and clear pulses.
module render_tile_scheduler_tile_unit_tracker
  import render_tile_scheduler_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       dispatch,
  input  tile_desc_t desc_in,
  input  logic       complete_en,
  input  logic       irq,
  output logic       busy,
  output logic       fire,
  output logic       do_render,
  output logic       clear_interrupt,
  output tile_desc_t desc
);

  logic       busy_q, busy_d;
  logic       do_render_q, do_render_d;
  logic       clear_q, clear_d;
  tile_desc_t desc_q, desc_d;

  // A completion is taken once: the unit must be busy and have no clear in flight.
  always_comb begin
    fire = complete_en & busy_q & irq & ~clear_q;
  end

  // Busy is set on dispatch and released the cycle after the clear pulse.
  always_comb begin
    busy_d      = busy_q;
    desc_d      = desc_q;
    do_render_d = dispatch;
    clear_d     = fire;
    if (dispatch) begin
      busy_d = 1'b1;
      desc_d = desc_in;
    end else if (clear_q) begin
      busy_d = 1'b0;
    end
  end

  // Tracker state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q      <= 1'b0;
      do_render_q <= 1'b0;
      clear_q     <= 1'b0;
      desc_q      <= '0;
    end else begin
      busy_q      <= busy_d;
      do_render_q <= do_render_d;
      clear_q     <= clear_d;
      desc_q      <= desc_d;
    end
  end

  assign busy            = busy_q;
  assign do_render       = do_render_q;
  assign clear_interrupt = clear_q;
  assign desc            = desc_q;

endmodule

// File: rtl/render_tile_scheduler.sv
// Frame-level scheduler: walks tiles in raster order, hands them to free
// render units and raises one frame interrupt when all tiles are back.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for do_frame; frame base and counters loaded on start
//   ST_RUN   | dispatching tiles (one per cycle max) and collecting completions
//   ST_DRAIN | all tiles dispatched; collecting the remaining completions
//   ST_DONE  | frame_irq high until clear_frame_irq
module render_tile_scheduler
  import render_tile_scheduler_pkg::*;
#(
  parameter int NUM_UNITS  = 4,
  parameter int TOTAL_ROWS = DEF_TOTAL_ROWS,
  parameter int TOTAL_COLS = DEF_TOTAL_COLS,
  parameter int TILE_ROWS  = DEF_TILE_ROWS,
  parameter int TILE_COLS  = DEF_TILE_COLS,
  parameter int POS_BITS   = DESC_POS_BITS,
  parameter int TILE_BITS  = $clog2(TOTAL_ROWS/TILE_ROWS*TOTAL_COLS/TILE_COLS)+1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               do_frame,
  input  logic [31:0]                        frame_pixel_buffer,
  input  logic                               clear_frame_irq,
  output logic                               frame_irq,
  output logic                               busy,
  output logic [TILE_BITS-1:0]               tiles_done,
  output logic [NUM_UNITS-1:0][POS_BITS-1:0] unit_start_row,
  output logic [NUM_UNITS-1:0][POS_BITS-1:0] unit_start_col,
  output logic [NUM_UNITS-1:0][31:0]         unit_pixel_buffer,
  output logic [NUM_UNITS-1:0]               unit_do_render,
  input  logic [NUM_UNITS-1:0]               unit_irq,
  output logic [NUM_UNITS-1:0]               unit_clear_interrupt
);

  localparam int TILES_X     = tiles_along(TOTAL_COLS, TILE_COLS);
  localparam int TILES_Y     = tiles_along(TOTAL_ROWS, TILE_ROWS);
  localparam int N_TILES     = TILES_X * TILES_Y;
  localparam int TILE_PIXELS = tile_pixels(TILE_ROWS, TILE_COLS);

  sched_state_t         state_q, state_d;
  logic [31:0]          base_q, base_d;
  logic [TILE_BITS-1:0] next_tile_q, next_tile_d;
  logic [TILE_BITS-1:0] tile_x_q, tile_x_d;
  logic [TILE_BITS-1:0] tile_y_q, tile_y_d;
  logic [TILE_BITS-1:0] tiles_done_q, tiles_done_d;

  logic [NUM_UNITS-1:0] unit_busy;
  logic [NUM_UNITS-1:0] unit_fire;
  logic [NUM_UNITS-1:0] grant;
  logic [NUM_UNITS-1:0] dispatch_vec;
  tile_desc_t           unit_desc [NUM_UNITS];
  tile_desc_t           next_desc;
  logic [31:0]          tile_index;
  logic [TILE_BITS-1:0] done_inc;
  logic                 run_dispatch;
  logic                 complete_en;
  logic                 dispatch_go;
  logic                 last_tile;

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (do_frame) state_d = ST_RUN;
      ST_RUN:   if (dispatch_go && last_tile) state_d = ST_DRAIN;
      ST_DRAIN: if ((tiles_done_q == TILE_BITS'(N_TILES)) && !(|unit_busy)) state_d = ST_DONE;
      ST_DONE:  if (clear_frame_irq) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    frame_irq    = (state_q == ST_DONE);
    complete_en  = busy;
    run_dispatch = (state_q == ST_RUN) && (next_tile_q < TILE_BITS'(N_TILES));
  end

  // Lowest-indexed free unit wins the next tile.
  always_comb begin
    grant = '0;
    for (int u = NUM_UNITS-1; u >= 0; u--) begin
      if (!unit_busy[u]) begin
        grant    = '0;
        grant[u] = 1'b1;
      end
    end
    dispatch_go  = run_dispatch && (|grant);
    dispatch_vec = dispatch_go ? grant : '0;
    last_tile    = (next_tile_q == TILE_BITS'(N_TILES-1));
  end

  // Descriptor for the tile at (tile_y, tile_x); addresses in 32 bits.
  always_comb begin
    tile_index             = 32'(tile_y_q) * 32'(TILES_X) + 32'(tile_x_q);
    next_desc.start_row    = DESC_POS_BITS'(32'(tile_y_q) * 32'(TILE_ROWS));
    next_desc.start_col    = DESC_POS_BITS'(32'(tile_x_q) * 32'(TILE_COLS));
    next_desc.pixel_buffer = base_q + tile_index * 32'(TILE_PIXELS);
  end

  // Frame counters: load on frame start, advance on dispatch, count completions.
  always_comb begin
    done_inc = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      done_inc = done_inc + TILE_BITS'(unit_fire[u]);
    end
    base_d       = base_q;
    next_tile_d  = next_tile_q;
    tile_x_d     = tile_x_q;
    tile_y_d     = tile_y_q;
    tiles_done_d = tiles_done_q + done_inc;
    if ((state_q == ST_IDLE) && do_frame) begin
      base_d       = frame_pixel_buffer;
      next_tile_d  = '0;
      tile_x_d     = '0;
      tile_y_d     = '0;
      tiles_done_d = '0;
    end
    if (dispatch_go) begin
      next_tile_d = next_tile_q + TILE_BITS'(1);
      if (tile_x_q == TILE_BITS'(TILES_X-1)) begin
        tile_x_d = '0;
        tile_y_d = tile_y_q + TILE_BITS'(1);
      end else begin
        tile_x_d = tile_x_q + TILE_BITS'(1);
      end
    end
  end

  // Frame counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q       <= '0;
      next_tile_q  <= '0;
      tile_x_q     <= '0;
      tile_y_q     <= '0;
      tiles_done_q <= '0;
    end else begin
      base_q       <= base_d;
      next_tile_q  <= next_tile_d;
      tile_x_q     <= tile_x_d;
      tile_y_q     <= tile_y_d;
      tiles_done_q <= tiles_done_d;
    end
  end

  assign tiles_done = tiles_done_q;

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    render_tile_scheduler_tile_unit_tracker u_tracker (
      .clock           (clock),
      .reset           (reset),
      .dispatch        (dispatch_vec[u]),
      .desc_in         (next_desc),
      .complete_en     (complete_en),
      .irq             (unit_irq[u]),
      .busy            (unit_busy[u]),
      .fire            (unit_fire[u]),
      .do_render       (unit_do_render[u]),
      .clear_interrupt (unit_clear_interrupt[u]),
      .desc            (unit_desc[u])
    );
  end

  // Unpack the per-unit descriptors onto the unit-facing buses.
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      unit_start_row[u]    = POS_BITS'(unit_desc[u].start_row);
      unit_start_col[u]    = POS_BITS'(unit_desc[u].start_col);
      unit_pixel_buffer[u] = unit_desc[u].pixel_buffer;
    end
  end

endmodule

// File: tb/tb_render_tile_scheduler.sv
// Bench: 2-unit 32x32 frame (dut_a) plus a 4-unit single-tile frame (dut_b).
module tb_render_tile_scheduler;

  localparam int NU = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // dut_a: 2 units, 2x2 tiles
  logic                   do_frame, clear_frame_irq;
  logic [31:0]            fpb;
  logic                   frame_irq, busy;
  logic [2:0]             tiles_done;
  logic [NU-1:0][8:0]     srow, scol;
  logic [NU-1:0][31:0]    spb;
  logic [NU-1:0]          dorender, uirq, uclr;

  render_tile_scheduler #(
    .NUM_UNITS(2), .TOTAL_ROWS(32), .TOTAL_COLS(32), .TILE_ROWS(16), .TILE_COLS(16)
  ) dut_a (
    .clock(clock), .reset(reset), .do_frame(do_frame), .frame_pixel_buffer(fpb),
    .clear_frame_irq(clear_frame_irq), .frame_irq(frame_irq), .busy(busy),
    .tiles_done(tiles_done), .unit_start_row(srow), .unit_start_col(scol),
    .unit_pixel_buffer(spb), .unit_do_render(dorender), .unit_irq(uirq),
    .unit_clear_interrupt(uclr)
  );

  // dut_b: 4 units, one 16x16 tile
  logic                   do_frame_b, clear_frame_irq_b;
  logic [31:0]            fpb_b;
  logic                   frame_irq_b, busy_b;
  logic [0:0]             tiles_done_b;
  logic [3:0][8:0]        srow_b, scol_b;
  logic [3:0][31:0]       spb_b;
  logic [3:0]             dorender_b, uirq_b, uclr_b;

  render_tile_scheduler #(
    .NUM_UNITS(4), .TOTAL_ROWS(16), .TOTAL_COLS(16), .TILE_ROWS(16), .TILE_COLS(16)
  ) dut_b (
    .clock(clock), .reset(reset), .do_frame(do_frame_b), .frame_pixel_buffer(fpb_b),
    .clear_frame_irq(clear_frame_irq_b), .frame_irq(frame_irq_b), .busy(busy_b),
    .tiles_done(tiles_done_b), .unit_start_row(srow_b), .unit_start_col(scol_b),
    .unit_pixel_buffer(spb_b), .unit_do_render(dorender_b), .unit_irq(uirq_b),
    .unit_clear_interrupt(uclr_b)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Unit model for dut_a: irq rises delay[u] cycles after do_render, drops on clear.
  int            delay [NU];
  int            cnt   [NU];
  logic [NU-1:0] irq_m, armed, force_irq;
  assign uirq = irq_m | force_irq;

  always @(negedge clock) begin
    for (int u = 0; u < NU; u++) begin
      if (reset) begin
        irq_m[u] = 1'b0; armed[u] = 1'b0; cnt[u] = 0;
      end else if (dorender[u]) begin
        cnt[u] = delay[u]; armed[u] = 1'b1; irq_m[u] = 1'b0;
      end else begin
        if (uclr[u]) irq_m[u] = 1'b0;
        if (armed[u]) begin
          cnt[u]--;
          if (cnt[u] == 0) begin irq_m[u] = 1'b1; armed[u] = 1'b0; end
        end
      end
    end
  end

  // Unit model for dut_b: unit 0 answers after 4 cycles; surplus units hold irq high.
  int   cnt_b;
  logic irq_b0;
  assign uirq_b = {3'b111, irq_b0};

  always @(negedge clock) begin
    if (reset) begin
      irq_b0 = 1'b0; cnt_b = 0;
    end else if (dorender_b[0]) begin
      cnt_b = 4;
    end else begin
      if (uclr_b[0]) irq_b0 = 1'b0;
      if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) irq_b0 = 1'b1;
      end
    end
  end

  logic surplus_seen = 1'b0;
  always @(negedge clock) begin
    if (reset === 1'b0 && ((dorender_b[3:1] | uclr_b[3:1]) != 3'b000)) surplus_seen = 1'b1;
  end

  // Scoreboard of expected dispatches for dut_a.
  typedef struct {
    int          unit;
    logic [8:0]  row;
    logic [8:0]  col;
    logic [31:0] pb;
  } exp_t;
  exp_t sb_q [$];
  exp_t mon_e;

  task automatic push_frame(input int u0, input int u1, input int u2, input int u3,
                            input logic [31:0] base);
    int   units [4];
    exp_t e;
    units = '{u0, u1, u2, u3};
    for (int i = 0; i < 4; i++) begin
      e.unit = units[i];
      e.row  = 9'((i / 2) * 16);
      e.col  = 9'((i % 2) * 16);
      e.pb   = base + 32'(i * 256);
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b0) begin
      chk("one_dispatch_per_cycle", 32'($countones(dorender) <= 1), 32'd1);
      for (int u = 0; u < NU; u++) begin
        if (dorender[u] === 1'b1) begin
          checks++;
          assert (sb_q.size() > 0) begin
            passes++;
            mon_e = sb_q.pop_front();
            chk("sb_unit", u, mon_e.unit);
            chk("sb_start_row", srow[u], mon_e.row);
            chk("sb_start_col", scol[u], mon_e.col);
            chk("sb_pixel_buffer", spb[u], mon_e.pb);
          end else $error("FAIL sb_unexpected_dispatch unit=%0d observed=pulse expected=none", u);
        end
      end
    end
  end

  task automatic start_frame(input logic [31:0] base);
    fpb = base;
    do_frame = 1'b1;
    @(negedge clock);
    do_frame = 1'b0;
    chk("start_busy", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (frame_irq !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_frame_irq"}, frame_irq, 1);
    chk({tag, "_tiles_done"}, tiles_done, 4);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_sb_drained"}, sb_q.size(), 0);
  endtask

  task automatic ack_irq(input string tag);
    clear_frame_irq = 1'b1;
    @(negedge clock);
    clear_frame_irq = 1'b0;
    chk({tag, "_irq_cleared"}, frame_irq, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0] td_prev;
    reset = 1'b1;
    do_frame = 1'b0; clear_frame_irq = 1'b0; fpb = '0; force_irq = '0;
    do_frame_b = 1'b0; clear_frame_irq_b = 1'b0; fpb_b = '0;
    delay = '{10, 10};
    repeat (3) @(negedge clock);

    chk("rst_frame_irq", frame_irq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tiles_done", tiles_done, 0);
    chk("rst_do_render", dorender, 0);
    chk("rst_clear", uclr, 0);
    chk("rst_pb0", spb[0], 0);
    chk("rst_row1", srow[1], 0);
    chk("rst_col1", scol[1], 0);
    reset = 1'b0;
    @(negedge clock);

    // Single tile, surplus units with irq held high.
    fpb_b = 32'h8000;
    do_frame_b = 1'b1;
    @(negedge clock);
    do_frame_b = 1'b0;
    n = 0;
    while (dorender_b === 4'b0000 && n < 20) begin @(negedge clock); n++; end
    chk("b_dispatch_unit", dorender_b, 4'b0001);
    chk("b_row", srow_b[0], 0);
    chk("b_col", scol_b[0], 0);
    chk("b_pb", spb_b[0], 32'h8000);
    n = 0;
    while (frame_irq_b !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    chk("b_frame_irq", frame_irq_b, 1);
    chk("b_tiles_done", tiles_done_b, 1);
    chk("b_busy_low", busy_b, 0);
    chk("b_surplus_never_pulsed", surplus_seen, 0);
    clear_frame_irq_b = 1'b1;
    @(negedge clock);
    clear_frame_irq_b = 1'b0;
    chk("b_irq_cleared", frame_irq_b, 0);

    // Frame 1: equal unit latency.
    push_frame(0, 1, 0, 1, 32'h1000);
    start_frame(32'h1000);
    wait_done("f1");
    ack_irq("f1");

    // Frame 2: both units complete together; do_frame pulsed mid-frame.
    delay = '{11, 10};
    push_frame(0, 1, 0, 1, 32'h2000);
    start_frame(32'h2000);
    td_prev = tiles_done;
    n = 0;
    while (uclr === 2'b00 && n < 60) begin
      td_prev = tiles_done;
      @(negedge clock);
      n++;
    end
    chk("same_cycle_clear", uclr, 2'b11);
    chk("same_cycle_td_before", td_prev, 0);
    chk("same_cycle_td_after", tiles_done, 2);
    @(negedge clock);
    chk("clear_one_cycle", uclr, 2'b00);
    do_frame = 1'b1;
    repeat (2) @(negedge clock);
    do_frame = 1'b0;
    chk("do_frame_ignored_busy", busy, 1);
    chk("do_frame_ignored_td", tiles_done, 2);
    wait_done("f2");
    ack_irq("f2");

    // Frame 3: fast unit 0, slow unit 1; stray irq on idle unit 0 during drain.
    delay = '{3, 40};
    push_frame(0, 1, 0, 0, 32'h3000);
    start_frame(32'h3000);
    n = 0;
    while (tiles_done !== 3'd3 && n < 100) begin @(negedge clock); n++; end
    chk("f3_fast_unit_done", tiles_done, 3);
    repeat (2) @(negedge clock);
    force_irq = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("idle_irq_no_clear", uclr[0], 0);
      chk("idle_irq_td_hold", tiles_done, 3);
    end
    force_irq = 2'b00;
    wait_done("f3");
    ack_irq("f3");

    // Frame 4: reset while running, then restart from tile (0,0).
    delay = '{10, 10};
    push_frame(0, 1, 0, 1, 32'h4000);
    start_frame(32'h4000);
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_irq", frame_irq, 0);
    chk("midrst_tiles_done", tiles_done, 0);
    chk("midrst_do_render", dorender, 0);
    chk("midrst_clear", uclr, 0);
    chk("midrst_rows", srow, 0);
    chk("midrst_cols", scol, 0);
    chk("midrst_pb0", spb[0], 0);
    chk("midrst_pb1", spb[1], 0);
    sb_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    push_frame(0, 1, 0, 1, 32'h5000);
    chk("restart_td_zero", tiles_done, 0);
    start_frame(32'h5000);
    wait_done("f4");

    // Frame 5: clear_frame_irq and do_frame together in DONE.
    push_frame(0, 1, 0, 1, 32'h6000);
    fpb = 32'h6000;
    clear_frame_irq = 1'b1;
    do_frame = 1'b1;
    @(negedge clock);
    clear_frame_irq = 1'b0;
    chk("both_irq_drops", frame_irq, 0);
    chk("both_idle_no_render", dorender, 0);
    @(negedge clock);
    do_frame = 1'b0;
    chk("both_run_busy", busy, 1);
    chk("both_run_no_render_yet", dorender, 0);
    @(negedge clock);
    chk("both_render_two_later", dorender, 2'b01);
    wait_done("f5");
    ack_irq("f5");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
